// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data requests from the
// datapath caches onto a single-ported RAM. Data wins arbitration unless
// it has already taken MAX_DSTREAK grants in a row while a fetch waits.
// A watchdog aborts any access that sees no ramready for TIMEOUT cycles.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;

    state_t        state, next_state;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_data;
    logic          lat_wr;
    logic [SW-1:0] dstreak;
    logic [WW-1:0] wdog;
    logic          grant_d, grant_i;
    logic          in_access;

    assign in_access = (state == IFETCH) || (state == DACCESS);

    // Arbitration, RAM strobes and completion/abort decode for the current state.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'h0;
        ramstore   = 32'h0;
        ihit       = 1'b0;
        iload      = 32'h0;
        dhit       = 1'b0;
        dload      = 32'h0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !(iREN && (dstreak == STREAK_MAX))) begin
                    grant_d    = 1'b1;
                    next_state = DACCESS;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    next_state = IFETCH;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = lat_addr;
                if (ramready) begin
                    // A flushed fetch still finishes on the bus but reports nothing.
                    ihit       = iREN;
                    iload      = iREN ? ramload : 32'h0;
                    next_state = IDLE;
                end else if (wdog == WD_LAST) begin
                    err        = 1'b1;
                    next_state = IDLE;
                end
            end
            DACCESS: begin
                ramREN   = ~lat_wr;
                ramWEN   = lat_wr;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (ramready) begin
                    dhit       = lat_wr ? dWEN : dREN;
                    dload      = (lat_wr ? dWEN : dREN) ? ramload : 32'h0;
                    next_state = IDLE;
                end else if (wdog == WD_LAST) begin
                    err        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; asynchronous reset drops every strobe immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Capture address, store data and op at grant; writes win when both ops are requested.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_addr <= 32'h0;
            lat_data <= 32'h0;
            lat_wr   <= 1'b0;
        end else if (grant_d) begin
            lat_addr <= daddr;
            lat_data <= dstore;
            lat_wr   <= dWEN;
        end else if (grant_i) begin
            lat_addr <= iaddr;
        end
    end

    // Count back-to-back data completions while a fetch waits, so fetch cannot starve.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if ((state == IDLE) && !iREN) begin
            dstreak <= '0;
        end else if ((state == IFETCH) && ramready) begin
            dstreak <= '0;
        end else if ((state == DACCESS) && ramready && iREN && (dstreak != STREAK_MAX)) begin
            dstreak <= dstreak + 1'b1;
        end
    end

    // Watchdog: counts access cycles without ramready, restarted at every grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdog <= '0;
        end else if (grant_d || grant_i) begin
            wdog <= '0;
        end else if (in_access && !ramready && (wdog != WD_LAST)) begin
            wdog <= wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

    localparam int MAXD = 4;
    localparam int TO   = 64;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, err;

    int errors = 0;
    int checks = 0;

    // Reference model: which transaction owns the RAM, and its captured request.
    int          m_kind;   // 0 = none, 1 = fetch, 2 = data
    logic        m_w;
    logic [31:0] m_addr, m_data;
    int          m_n;      // 1-based count of the current access cycle
    int          m_streak; // data grants completed in a row with a fetch waiting

    mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kind = 0; m_w = 0; m_addr = 0; m_data = 0; m_n = 0; m_streak = 0;
    endtask

    // Drive one cycle of inputs, check all outputs against the model, advance the model.
    task automatic step(input logic i = 0, input logic r = 0, input logic w = 0,
                        input logic rr = 0, input logic [31:0] ia = 0,
                        input logic [31:0] da = 0, input logic [31:0] ds = 0,
                        input logic [31:0] rl = 0);
        logic        e_ren, e_wen, e_ihit, e_dhit, e_err;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        @(negedge CLK);
        iREN = i; dREN = r; dWEN = w; ramready = rr;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
        #1;
        e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0; e_err = 0;
        e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
        if (m_kind == 1) begin
            e_ren = 1; e_addr = m_addr;
            if (rr) begin e_ihit = i; e_iload = i ? rl : 32'h0; end
            else if (m_n == TO) e_err = 1;
        end else if (m_kind == 2) begin
            e_ren = !m_w; e_wen = m_w; e_addr = m_addr; e_store = m_data;
            if (rr) begin
                e_dhit  = m_w ? w : r;
                e_dload = e_dhit ? rl : 32'h0;
            end else if (m_n == TO) e_err = 1;
        end
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("ihit", ihit, e_ihit);
        chk("iload", iload, e_iload);
        chk("dhit", dhit, e_dhit);
        chk("dload", dload, e_dload);
        chk("err", err, e_err);
        chk("hit_exclusive", ihit & dhit, 0);
        // advance the model to the next cycle
        if (m_kind == 0) begin
            if ((r || w) && !(i && m_streak == MAXD)) begin
                m_kind = 2; m_w = w; m_addr = da; m_data = ds; m_n = 1;
            end else if (i) begin
                m_kind = 1; m_addr = ia; m_n = 1;
            end
            if (!i) m_streak = 0;
        end else if (rr) begin
            if (m_kind == 1) m_streak = 0;
            else if (i && m_streak < MAXD) m_streak = m_streak + 1;
            m_kind = 0;
        end else if (m_n == TO) begin
            m_kind = 0;
        end else begin
            m_n = m_n + 1;
        end
    endtask

    initial begin
        int ndhit, seen_ihit, pct;
        logic ri, rr_, rw;
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        model_reset();
        #2;
        chk("reset_ramREN", ramREN, 0);
        chk("reset_ihit", ihit, 0);
        chk("reset_err", err, 0);
        @(negedge CLK); nRST = 1;

        // Reset in the middle of a data write
        step(0, 0, 1, 0, 0, 32'h100, 32'h5555AAAA);
        step(0, 0, 1, 0, 0, 32'h100, 32'h5555AAAA);
        chk("rst_pre_ramWEN", ramWEN, 1);
        step(0, 0, 1, 0, 0, 32'h100, 32'h5555AAAA);
        #2 nRST = 0;
        #1;
        chk("rst_async_ramWEN", ramWEN, 0);
        chk("rst_async_ramaddr", ramaddr, 0);
        chk("rst_async_ramstore", ramstore, 0);
        dWEN = 0;
        model_reset();
        @(negedge CLK); nRST = 1;
        step();
        chk("rst_after_dhit", dhit, 0);
        step();

        // Single fetch with ramready two cycles after the strobe
        step(1, 0, 0, 0, 32'h40);
        chk("f_c0_ramREN", ramREN, 0);
        step(1, 0, 0, 0, 32'h40);
        chk("f_c1_ramREN", ramREN, 1);
        chk("f_c1_ramaddr", ramaddr, 32'h40);
        step(1, 0, 0, 0, 32'h40);
        step(1, 0, 0, 1, 32'h40, 0, 0, 32'hDEADBEEF);
        chk("f_c3_ihit", ihit, 1);
        chk("f_c3_iload", iload, 32'hDEADBEEF);
        step(1, 0, 0, 0, 32'h40);
        chk("f_c4_idle", ramREN, 0);
        step(1, 0, 0, 0, 32'h40);
        chk("f_c5_regrant", ramREN, 1);
        step(0, 0, 0, 1);
        step();

        // Simultaneous fetch and data read: data first, turnaround, then fetch
        step(1, 1, 0, 0, 32'h44, 32'h204);
        step(1, 1, 0, 1, 32'h44, 32'h204, 0, 32'h12345678);
        chk("pri_dhit", dhit, 1);
        chk("pri_dload", dload, 32'h12345678);
        step(1, 0, 0, 0, 32'h44);
        chk("pri_turnaround", ramREN, 0);
        step(1, 0, 0, 1, 32'h44, 0, 0, 32'hCAFEF00D);
        chk("pri_fetch_addr", ramaddr, 32'h44);
        chk("pri_ihit", ihit, 1);
        step();

        // Bounded data streak with a fetch pending
        ndhit = 0; seen_ihit = 0;
        for (int k = 0; k < 40 && !seen_ihit; k++) begin
            step(1, 0, 1, 1, 32'h48, 32'h300 + k, k, 32'hA0 + k);
            if (dhit) ndhit++;
            if (ihit) seen_ihit = 1;
        end
        chk("streak_dhits", ndhit, MAXD);
        chk("streak_fetch_won", seen_ihit, 1);
        step();

        // Fetch flushed after grant: no ihit, next data request served normally
        step(1, 0, 0, 0, 32'h80);
        step(1, 0, 0, 0, 32'h80);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 32'h77);
        chk("flush_no_ihit", ihit, 0);
        step(0, 1, 0, 0, 0, 32'h200);
        chk("flush_idle", ramREN, 0);
        step(0, 1, 0, 1, 0, 32'h200, 0, 32'h99);
        chk("flush_daddr", ramaddr, 32'h200);
        chk("flush_dhit", dhit, 1);
        step();

        // Watchdog abort
        step(0, 1, 0, 0, 0, 32'h300);
        for (int n = 1; n <= TO; n++) begin
            step(0, 1, 0, 0, 0, 32'h300);
            if (n == TO) begin
                chk("to_err", err, 1);
                chk("to_no_dhit", dhit, 0);
            end
        end
        step(0, 0, 0, 0);
        chk("to_after_ramREN", ramREN, 0);

        // Randomized traffic with varying RAM responsiveness
        ri = 0; rr_ = 0; rw = 0;
        for (int blk = 0; blk < 8; blk++) begin
            pct = (blk % 4 == 1) ? 0 : 20 + 20 * (blk % 4);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(5) == 0) ri = ~ri;
                if ($urandom_range(4) == 0) rr_ = ~rr_;
                if ($urandom_range(4) == 0) rw = ~rw;
                step(ri, rr_, rw, ($urandom_range(99) < pct),
                     $urandom, $urandom, $urandom, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's ihit/dhit stall protocol.
- Accepts instruction-fetch and data requests from the datapath caches and serialises them onto a single-ported RAM interface.
- Returns ihit/dhit/iload/dload to the pipeline and hazard logic.
- Data has priority, with a bounded streak so fetch cannot starve; a watchdog aborts hung RAM accesses.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while a fetch is pending before the fetch must win.
- TIMEOUT, 64: cycles in an access state without ramready before abort.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction read request (level, held until ihit)
- iaddr  input  32  fetch address
- iload  output  32  fetch data, valid when ihit=1
- ihit  output  1  fetch complete, single-cycle pulse
- dREN  input  1  data read request (level)
- dWEN  input  1  data write request (level)
- daddr  input  32  data address
- dstore  input  32  write data
- dload  output  32  read data, valid when dhit=1
- dhit  output  1  data access complete, single-cycle pulse
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramready  input  1  RAM access complete, sampled only in access states
- err  output  1  timeout abort, single-cycle pulse

Behaviour:
- FSM states: IDLE, IFETCH, DACCESS.
- Reset (async): state=IDLE, counters=0, latched addr/data/op=0. All outputs are 0 during reset and immediately on assertion, including mid-access.
- IDLE arbitration on a cycle with no wait:
  - If (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK) -> DACCESS.
  - Else if iREN -> IFETCH.
  - Else stay in IDLE.
- Grant latches the address, plus for data the store data and op. If dREN and dWEN are both set, the op is write.
- In IFETCH: ramREN=1, ramaddr=latched iaddr.
- In DACCESS: ramREN or ramWEN per latched op, ramaddr/ramstore from latches. Strobes are 0 in IDLE.
- Access completes on ramready=1 in an access state:
  - ihit (or dhit) = 1 combinationally that cycle, only if the original request is still asserted.
  - iload/dload = ramload; otherwise iload/dload=0.
  - Next state IDLE. This gives a mandatory one-cycle turnaround, so the requester's still-high REN is never re-granted.
- Request withdrawn mid-access (flush): the access runs to ramready or timeout, the hit is suppressed, and there is no abort of the RAM strobe.
- Latency: request first seen in IDLE at cycle 0 -> strobes at cycle 1 -> hit in the cycle ramready arrives (earliest cycle 1).
- dstreak (width clog2(MAX_DSTREAK+1)):
  - Increments on data completion while iREN=1, saturating at MAX_DSTREAK.
  - Clears on fetch completion or when iREN=0 in IDLE.
- Watchdog counter:
  - Clears on entering an access state and increments each access cycle without ramready.
  - When it reaches TIMEOUT-1 with ramready=0: err=1 that cycle, no hit, next state IDLE, dstreak unchanged.
  - ramready in the same cycle wins over timeout.
- ihit and dhit are never asserted in the same cycle. Hits and err are never asserted in the same cycle.

Test Plan:
- Reset mid-DACCESS write (daddr=0x100, ramready held 0): nRST low -> ramWEN drops asynchronously; after release state=IDLE with no hit.
- iREN only, iaddr=0x0040, ramready 2 cycles after strobe with ramload=0xDEADBEEF -> ramREN cycles 1-3, ihit=1 and iload=0xDEADBEEF in cycle 3, IDLE in cycle 4, re-grant in cycle 5.
- iREN and dREN simultaneously -> DACCESS first, dhit, one IDLE cycle, then IFETCH.
- iREN held, dWEN continuously re-asserted, MAX_DSTREAK=4 -> exactly 4 dhit pulses, then an IFETCH grant while dWEN=1.
- iREN dropped one cycle after grant, ramready in cycle 3 -> no ihit, FSM returns to IDLE, next dREN granted normally.
- DACCESS with ramready never asserted, TIMEOUT=64 -> err pulses in the 64th access cycle, no dhit, ramREN=0 the following cycle.
